disp_timing_gen: RTL
====================

# disp_timing_gen

Parametrised display timing generator for the display path. It produces HSYNC/VSYNC/DE for VGA, XGA and SXGA, selected at run time. It also issues an early pixel-request strobe so that the display FIFO read latency is hidden. The resolution select and the display enable are sampled only at frame boundaries, so a mid-frame DISPON write never produces a torn frame.

## Interface
Parameters:
- OUT_DELAY, 2: pipeline stages between PIX_REQ and the DSP_* sync/DE outputs; this equals the FIFO read latency; legal range 0..7
- CNT_WIDTH, 11: width of the internal H/V counters; must hold 1688-1

Ports:
- DCLK  in  1  pixel clock; the only clock in the block
- DRST  in  1  reset; synchronous, active-high
- RESOL  in  2  resolution select: 00 VGA, 01 XGA, 10 SXGA, 11 is treated as VGA
- DISPON  in  1  display enable (register bit)
- PIX_REQ  out  1  request one pixel from the FIFO; this is DE advanced by OUT_DELAY cycles
- DSP_HSYNC_X  out  1  horizontal sync, active low
- DSP_VSYNC_X  out  1  vertical sync, active low
- DSP_DE  out  1  data enable
- FRAME_START  out  1  one-cycle pulse on the cycle the counters wrap to (0,0)
- VBLANK_IRQ  out  1  one-cycle pulse at the first pixel of line VACT
- HCNT, VCNT  out  CNT_WIDTH  current undelayed counters

## Operation
Timing tables (HACT/HFP/HSYNC/HBP, VACT/VFP/VSYNC/VBP):
- VGA: 640/16/96/48 (HTOTAL 800), 480/10/2/33 (VTOTAL 525)
- XGA: 1024/24/136/160 (HTOTAL 1344), 768/3/6/29 (VTOTAL 806)
- SXGA: 1280/48/112/248 (HTOTAL 1688), 1024/1/3/38 (VTOTAL 1066)

Counters:
- HCNT runs 0..HTOTAL-1 and wraps to 0.
- VCNT increments when HCNT wraps, and wraps to 0 after VTOTAL-1.

Region decode (undelayed):
- Active: HCNT < HACT and VCNT < VACT.
- hsync asserted for HACT+HFP <= HCNT < HACT+HFP+HSYNC.
- vsync asserted for VACT+VFP <= VCNT < VACT+VFP+VSYNC, for whole lines (aligned to HCNT=0).

Frame-boundary latch. On the cycle (HCNT=HTOTAL-1, VCNT=VTOTAL-1), both inputs are captured into cur_resol and cur_en:
- cur_resol takes RESOL (11 becomes 00).
- cur_en takes DISPON.
- All decodes use the latched values only. Changing RESOL or DISPON mid-frame has no effect until the next frame.

Enable behaviour:
- When cur_en=0, PIX_REQ and DE stay 0 while HSYNC, VSYNC, FRAME_START and VBLANK_IRQ keep running. The monitor therefore stays locked.

Resolution change:
- A resolution change takes effect on the first cycle of the new frame (0,0).
- There are no partial lines.

Output path:
- PIX_REQ = active & cur_en, undelayed.
- {hsync, vsync, de} pass through an OUT_DELAY-deep shift register before reaching DSP_*.
- With OUT_DELAY=0 the DSP_* outputs are combinational from registered counters, and DSP_DE = PIX_REQ.

Pulses (undelayed, aligned with HCNT/VCNT):
- FRAME_START: HCNT=0, VCNT=0.
- VBLANK_IRQ: HCNT=0, VCNT=VACT.

## Timing
- Reset (DRST=1 at a DCLK edge) takes effect on that edge:
  - HCNT=0, VCNT=0, cur_resol=00, cur_en=0.
  - Delay line filled with idle {1,1,0}.
  - Outputs: DSP_HSYNC_X=1, DSP_VSYNC_X=1, DSP_DE=0, PIX_REQ=0, FRAME_START=0, VBLANK_IRQ=0.
- First cycle after reset release: counters are at (0,0), but FRAME_START is 0. The first pulse comes at the first natural wrap, and the latch fires on the cycle before it.
- Reset mid-frame behaves identically. The delay line is flushed and no residual DE pulses appear.
- Latency: DSP_* = undelayed decode delayed by exactly OUT_DELAY DCLK cycles. PIX_REQ leads DSP_DE by OUT_DELAY cycles.
- Per frame: DE high count = HACT×VACT when enabled. Every line's DE run is contiguous for HACT cycles.
- DISPON rising and falling in the same frame without spanning the latch cycle: no effect.

## Test plan
- Reset release, RESOL=00, DISPON=1 held: the first frame has DE=0 (cur_en still 0). From the second frame on, DE counts 640 per line × 480 lines. HSYNC_X is low for 96 cycles starting at HCNT 656. VSYNC_X is low for lines 490–491. The frame period is 420000 DCLK.
- DISPON 0→1 written mid-frame at VCNT=200: DE stays 0 for the rest of that frame. The next frame contains exactly 307200 DE cycles.
- RESOL switched 00→10 mid-frame: the current frame completes at 800×525. The next frame is 1688×1066 with DE 1280×1024. HSYNC_X goes low at HCNT 1328 for 112 cycles.
- OUT_DELAY=2, XGA: every PIX_REQ rise is followed by a DSP_DE rise exactly 2 cycles later. The hsync edges are likewise shifted by 2 relative to HCNT decode.
- DRST pulsed at VGA (VCNT=100, HCNT=300) with DE high: the outputs are idle values on the next cycle, no DE appears during the OUT_DELAY flush, and counters restart at (0,0).
- RESOL=11: timing identical to VGA. VBLANK_IRQ pulses once per frame at VCNT=480, HCNT=0.

Source files
------------

// File: rtl/disp_timing_gen.sv
// Display timing generator: H/V counters, sync/DE decode for VGA/XGA/SXGA,
// an early pixel-request strobe, and a sync/DE delay line matching FIFO latency.
// Resolution and enable are latched only on the last pixel of a frame.
// Timing tables are packed {ACT, FP, SYNC, BP}, 16 bits per field.
module disp_timing_gen #(
  parameter int          OUT_DELAY = 2,
  parameter int          CNT_WIDTH = 11,
  parameter logic [63:0] VGA_H     = {16'd640,  16'd16, 16'd96,  16'd48},
  parameter logic [63:0] VGA_V     = {16'd480,  16'd10, 16'd2,   16'd33},
  parameter logic [63:0] XGA_H     = {16'd1024, 16'd24, 16'd136, 16'd160},
  parameter logic [63:0] XGA_V     = {16'd768,  16'd3,  16'd6,   16'd29},
  parameter logic [63:0] SXGA_H    = {16'd1280, 16'd48, 16'd112, 16'd248},
  parameter logic [63:0] SXGA_V    = {16'd1024, 16'd1,  16'd3,   16'd38}
) (
  input  logic                 DCLK,
  input  logic                 DRST,
  input  logic [1:0]           RESOL,
  input  logic                 DISPON,
  output logic                 PIX_REQ,
  output logic                 DSP_HSYNC_X,
  output logic                 DSP_VSYNC_X,
  output logic                 DSP_DE,
  output logic                 FRAME_START,
  output logic                 VBLANK_IRQ,
  output logic [CNT_WIDTH-1:0] HCNT,
  output logic [CNT_WIDTH-1:0] VCNT
);

  localparam logic [2:0] IDLE = 3'b110;  // {hsync_x, vsync_x, de}

  logic [CNT_WIDTH-1:0] hcnt_p0, vcnt_p0;
  logic [1:0]           cur_resol;
  logic                 cur_en;
  logic                 frame_start_p1;
  logic [63:0]          tab_h, tab_v;
  logic [CNT_WIDTH-1:0] hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
  logic [CNT_WIDTH-1:0] htotal, vtotal;
  logic                 h_last, v_last, frame_last;
  logic                 active, hs, vs;
  logic [2:0]           dec_p0, out_pn;

  // Timing table for the resolution latched at the last frame boundary
  always_comb begin
    case (cur_resol)
      2'b01:   begin tab_h = XGA_H;  tab_v = XGA_V;  end
      2'b10:   begin tab_h = SXGA_H; tab_v = SXGA_V; end
      default: begin tab_h = VGA_H;  tab_v = VGA_V;  end
    endcase
  end

  assign hact = CNT_WIDTH'(tab_h[63:48]);
  assign hfp  = CNT_WIDTH'(tab_h[47:32]);
  assign hsw  = CNT_WIDTH'(tab_h[31:16]);
  assign hbp  = CNT_WIDTH'(tab_h[15:0]);
  assign vact = CNT_WIDTH'(tab_v[63:48]);
  assign vfp  = CNT_WIDTH'(tab_v[47:32]);
  assign vsw  = CNT_WIDTH'(tab_v[31:16]);
  assign vbp  = CNT_WIDTH'(tab_v[15:0]);

  assign htotal     = hact + hfp + hsw + hbp;
  assign vtotal     = vact + vfp + vsw + vbp;
  assign h_last     = (hcnt_p0 == htotal - CNT_WIDTH'(1));
  assign v_last     = (vcnt_p0 == vtotal - CNT_WIDTH'(1));
  assign frame_last = h_last && v_last;

  // Counters, frame-boundary latch of RESOL/DISPON, and the frame-start pulse
  always_ff @(posedge DCLK) begin
    if (DRST) begin
      hcnt_p0        <= '0;
      vcnt_p0        <= '0;
      cur_resol      <= 2'b00;
      cur_en         <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= frame_last;
      if (h_last) begin
        hcnt_p0 <= '0;
        vcnt_p0 <= v_last ? '0 : vcnt_p0 + CNT_WIDTH'(1);
      end else begin
        hcnt_p0 <= hcnt_p0 + CNT_WIDTH'(1);
      end
      if (frame_last) begin
        cur_resol <= (RESOL == 2'b11) ? 2'b00 : RESOL;
        cur_en    <= DISPON;
      end
    end
  end

  // Undelayed region decode
  always_comb begin
    active  = (hcnt_p0 < hact) && (vcnt_p0 < vact);
    hs      = (hcnt_p0 >= hact + hfp) && (hcnt_p0 < hact + hfp + hsw);
    vs      = (vcnt_p0 >= vact + vfp) && (vcnt_p0 < vact + vfp + vsw);
    PIX_REQ = active && cur_en;
    dec_p0  = {~hs, ~vs, PIX_REQ};
  end

  generate
    if (OUT_DELAY == 0) begin : g_nodelay
      assign out_pn = dec_p0;
    end else begin : g_delay
      logic [2:0] dly_p [OUT_DELAY];
      // Sync/DE shift register; reset flushes it to idle so no stale DE escapes
      always_ff @(posedge DCLK) begin
        if (DRST) begin
          for (int i = 0; i < OUT_DELAY; i++) dly_p[i] <= IDLE;
        end else begin
          dly_p[0] <= dec_p0;
          for (int i = 1; i < OUT_DELAY; i++) dly_p[i] <= dly_p[i-1];
        end
      end
      assign out_pn = dly_p[OUT_DELAY-1];
    end
  endgenerate

  assign DSP_HSYNC_X = out_pn[2];
  assign DSP_VSYNC_X = out_pn[1];
  assign DSP_DE      = out_pn[0];
  assign FRAME_START = frame_start_p1;
  assign VBLANK_IRQ  = (hcnt_p0 == '0) && (vcnt_p0 == vact);
  assign HCNT        = hcnt_p0;
  assign VCNT        = vcnt_p0;

endmodule
